// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues icache requests, pairs each
// synchronous icache response with its PC, and hands valid/instr/pc to decode.
// A one-entry skid buffer absorbs decode hold; redirects squash wrong-path work.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        hold,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] icache_addr,
  output logic        icache_re,
  input  logic [31:0] icache_dout,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid
);

  logic [31:0] pc_reg, pc_next;
  logic [31:0] resp_pc_reg, resp_pc_next;
  logic        resp_valid_reg, resp_valid_next;
  logic [31:0] buf_reg, buf_next;
  logic [31:0] buf_pc_reg, buf_pc_next;
  logic        buf_valid_reg, buf_valid_next;
  logic        run_reg;
  logic        issue;
  logic        consume;

  // Request/presentation decode; the skid buffer always has priority on the
  // output because it holds the older instruction.
  always_comb begin
    issue       = run_reg & ~stall & ~hold & ~redirect_valid;
    icache_re   = issue;
    icache_addr = pc_reg;
    instr       = buf_valid_reg ? buf_reg    : icache_dout;
    instr_pc    = buf_valid_reg ? buf_pc_reg : resp_pc_reg;
    instr_valid = run_reg & ~stall & ~redirect_valid &
                  (buf_valid_reg | resp_valid_reg);
    consume     = instr_valid & ~hold;
  end

  // Next-state: redirect beats stall beats everything else.
  always_comb begin
    pc_next         = pc_reg;
    resp_pc_next    = resp_pc_reg;
    resp_valid_next = resp_valid_reg;
    buf_next        = buf_reg;
    buf_pc_next     = buf_pc_reg;
    buf_valid_next  = buf_valid_reg;
    if (redirect_valid) begin
      // Any in-flight response or buffered entry is wrong-path now.
      pc_next         = {redirect_pc[31:2], 2'b00};
      resp_valid_next = 1'b0;
      buf_valid_next  = 1'b0;
    end else if (!stall) begin
      if (buf_valid_reg && consume) begin
        buf_valid_next = 1'b0;
      end
      if (issue) begin
        // Issue implies no hold, so any pending response is consumed now.
        resp_pc_next    = pc_reg;
        resp_valid_next = 1'b1;
        pc_next         = pc_reg + 32'd4;
      end else if (resp_valid_reg) begin
        if (hold && !buf_valid_reg) begin
          // The cache only drives this data for one cycle; park it.
          buf_next        = icache_dout;
          buf_pc_next     = resp_pc_reg;
          buf_valid_next  = 1'b1;
          resp_valid_next = 1'b0;
        end else if (!hold) begin
          resp_valid_next = 1'b0;
        end
      end
    end
  end

  // State register; run_reg delays the first fetch to the edge after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg         <= RESET_PC;
      resp_pc_reg    <= 32'd0;
      resp_valid_reg <= 1'b0;
      buf_reg        <= 32'd0;
      buf_pc_reg     <= 32'd0;
      buf_valid_reg  <= 1'b0;
      run_reg        <= 1'b0;
    end else begin
      pc_reg         <= pc_next;
      resp_pc_reg    <= resp_pc_next;
      resp_valid_reg <= resp_valid_next;
      buf_reg        <= buf_next;
      buf_pc_reg     <= buf_pc_next;
      buf_valid_reg  <= buf_valid_next;
      run_reg        <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural synchronous icache.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, hold, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] icache_addr;
  logic        icache_re;
  logic [31:0] icache_dout;
  logic [31:0] instr, instr_pc;
  logic        instr_valid;

  int checks   = 0;
  int failures = 0;

  fetch_unit #(.RESET_PC(32'h0000_2000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .hold(hold),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .icache_addr(icache_addr), .icache_re(icache_re),
    .icache_dout(icache_dout), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid)
  );

  always #5 clk = ~clk;

  // Instruction word stored at each address.
  function automatic logic [31:0] code(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // Cache model: data for the last accepted request, garbage while stalled.
  logic [31:0] last_addr = 32'd0;
  always @(posedge clk) begin
    if (icache_re) last_addr <= icache_addr;
  end
  assign icache_dout = stall ? 32'hDEAD_BEEF : code(last_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Buffer and response register must never both hold live entries.
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (dut.buf_valid_reg && dut.resp_valid_reg) begin
        failures++;
        $display("FAIL invariant: buf_valid=1 resp_valid=1 expected not both");
      end
    end
  end

  typedef struct {
    logic        s, h, r;
    logic [31:0] rpc;
    logic        e_re;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic h, input logic r, input logic [31:0] rpc,
                     input logic e_re, input logic [31:0] e_addr,
                     input logic e_valid, input logic [31:0] e_pc);
    vec_t v;
    v.s = s; v.h = h; v.r = r; v.rpc = rpc;
    v.e_re = e_re; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
    vecs.push_back(v);
  endtask

  task automatic chk_out(input string tag, input logic e_re, input logic [31:0] e_addr,
                         input logic e_valid, input logic [31:0] e_pc);
    chk({tag, ".re"}, 32'(icache_re), 32'(e_re));
    chk({tag, ".addr"}, icache_addr, e_addr);
    chk({tag, ".valid"}, 32'(instr_valid), 32'(e_valid));
    if (e_valid) begin
      chk({tag, ".pc"}, instr_pc, e_pc);
      chk({tag, ".instr"}, instr, code(e_pc));
    end
  endtask

  initial begin
    // stall hold redir rpc            re  addr          valid pc
    add(1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_2000, 1'b0, 32'h0);          // 1
    add(1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_2004, 1'b1, 32'h0000_2000);  // 2
    add(1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_2008, 1'b1, 32'h0000_2004);  // 3
    add(1'b0, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0000_200C, 1'b1, 32'h0000_2008);  // hold
    add(1'b0, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0000_200C, 1'b1, 32'h0000_2008);
    add(1'b0, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0000_200C, 1'b1, 32'h0000_2008);
    add(1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_200C, 1'b1, 32'h0000_2008);  // drain buf
    add(1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_2010, 1'b1, 32'h0000_200C);
    add(1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0000_2014, 1'b0, 32'h0);          // stall x4
    add(1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0000_2014, 1'b0, 32'h0);
    add(1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0000_2014, 1'b0, 32'h0);
    add(1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0000_2014, 1'b0, 32'h0);
    add(1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_2014, 1'b1, 32'h0000_2010);
    add(1'b0, 1'b0, 1'b1, 32'h0000_3003,  1'b0, 32'h0000_2018, 1'b0, 32'h0);          // redirect
    add(1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_3000, 1'b0, 32'h0);
    add(1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_3004, 1'b1, 32'h0000_3000);
    add(1'b0, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0000_3008, 1'b1, 32'h0000_3004);  // buffer 3004
    add(1'b1, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0000_3008, 1'b0, 32'h0);          // stall+hold
    add(1'b1, 1'b1, 1'b1, 32'h0000_4000,  1'b0, 32'h0000_3008, 1'b0, 32'h0);          // redirect in stall
    add(1'b1, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0000_4000, 1'b0, 32'h0);
    add(1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_4000, 1'b0, 32'h0);
    add(1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_4004, 1'b1, 32'h0000_4000);
    add(1'b0, 1'b0, 1'b1, 32'h0000_5000,  1'b0, 32'h0000_4008, 1'b0, 32'h0);          // back-to-back
    add(1'b0, 1'b0, 1'b1, 32'h0000_6004,  1'b0, 32'h0000_5000, 1'b0, 32'h0);
    add(1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_6004, 1'b0, 32'h0);
    add(1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_6008, 1'b1, 32'h0000_6004);
    add(1'b1, 1'b0, 1'b1, 32'h0000_7000,  1'b0, 32'h0000_600C, 1'b0, 32'h0);          // redirect+stall
    add(1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_7000, 1'b0, 32'h0);          // 6008 squashed
    add(1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_7004, 1'b1, 32'h0000_7000);
    add(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF,  1'b0, 32'h0000_7008, 1'b0, 32'h0);          // wrap
    add(1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    add(1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC);

    reset = 1'b1; stall = 1'b0; hold = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(negedge clk);
    #1 chk_out("reset", 1'b0, 32'h0000_2000, 1'b0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk_out("cycle0", 1'b0, 32'h0000_2000, 1'b0, 32'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      stall = vecs[i].s; hold = vecs[i].h;
      redirect_valid = vecs[i].r; redirect_pc = vecs[i].rpc;
      #1;
      $display("vec %0d s=%0b h=%0b r=%0b re=%0b addr=%h valid=%0b pc=%h instr=%h",
               i, stall, hold, redirect_valid, icache_re, icache_addr,
               instr_valid, instr_pc, instr);
      chk_out($sformatf("vec%0d", i), vecs[i].e_re, vecs[i].e_addr,
              vecs[i].e_valid, vecs[i].e_pc);
    end

    // Reset asserted while the skid buffer holds an instruction.
    @(negedge clk);
    stall = 1'b0; hold = 1'b1; redirect_valid = 1'b0;
    #1 chk_out("mid.hold0", 1'b0, 32'h0000_0004, 1'b1, 32'h0000_0000);
    @(negedge clk);
    #1 chk_out("mid.buf", 1'b0, 32'h0000_0004, 1'b1, 32'h0000_0000);
    #1 reset = 1'b1;
    #1 chk_out("mid.reset", 1'b0, 32'h0000_2000, 1'b0, 32'h0);
    $display("mid-stream reset: re=%0b addr=%h valid=%0b", icache_re, icache_addr, instr_valid);
    @(negedge clk);
    reset = 1'b0; hold = 1'b0;
    #1 chk_out("restart0", 1'b0, 32'h0000_2000, 1'b0, 32'h0);
    @(negedge clk);
    #1 chk_out("restart1", 1'b1, 32'h0000_2000, 1'b0, 32'h0);
    @(negedge clk);
    #1 chk_out("restart2", 1'b1, 32'h0000_2004, 1'b1, 32'h0000_2000);
    $display("restart: addr=%h valid=%0b pc=%h", icache_addr, instr_valid, instr_pc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
